// File: rtl/bz_host_core_if.sv
// Host word-stream and board-to-board flit link signals for bz_host_core.
// The slave modport is the core's view; master is the environment's view.
interface bz_host_core_if;
    logic [31:0] host_dn_data;
    logic        host_dn_valid;
    logic        host_dn_ready;
    logic [31:0] host_up_data;
    logic        host_up_valid;
    logic        host_up_ready;
    logic [10:0] top_out;
    logic        top_valid_out;
    logic        top_ready_in;
    logic [10:0] top_in;
    logic        top_valid_in;
    logic        top_ready_out;

    modport slave (
        input  host_dn_data, host_dn_valid,
        output host_dn_ready,
        output host_up_data, host_up_valid,
        input  host_up_ready,
        output top_out, top_valid_out,
        input  top_ready_in,
        input  top_in, top_valid_in,
        output top_ready_out
    );

    modport master (
        output host_dn_data, host_dn_valid,
        input  host_dn_ready,
        input  host_up_data, host_up_valid,
        output host_up_ready,
        input  top_out, top_valid_out,
        output top_ready_in,
        output top_in, top_valid_in,
        input  top_ready_out
    );
endinterface

// File: rtl/bz_host_core.sv
// Host word stream <-> 11-bit flit link bridge: decodes config writes / NOPs / packets
// downstream and serializes them; reassembles inbound flits into host word pairs.
module bz_host_core #(
    parameter int NREG = 32,
    parameter int RTW  = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bz_host_core_if.slave        bus,
    output logic [NREG*16-1:0]   conf_regs,
    output logic [3:0]           led
);
    localparam int FW   = 11;
    localparam int RIDW = $clog2(NREG);

    localparam logic [0:0] S_WORD  = 1'b0;
    localparam logic [0:0] S_ROUTE = 1'b1;

    logic              r_rdy_en;
    logic [0:0]        r_dn_state;
    logic [31:0]       r_payload;
    logic [15:0]       r_conf [NREG];

    logic              r_buf_valid;
    logic [RTW-1:0]    r_buf_route;
    logic [31:0]       r_buf_payload;

    logic              r_ser_busy;
    logic [1:0]        r_ser_idx;
    logic [RTW-1:0]    r_ser_route;
    logic [31:0]       r_ser_payload;

    logic [1:0]        r_des_idx;
    logic              r_des_full;
    logic              r_up_sel;
    logic [FW-1:0]     r_des_h;
    logic [FW-1:0]     r_des_d0;
    logic [FW-1:0]     r_des_d1;
    logic [9:0]        r_des_d2;

    logic [1:0]        r_dn_cnt;
    logic [1:0]        r_up_cnt;

    logic              w_dn_fire;
    logic              w_is_ctl;
    logic              w_conf_wr;
    logic              w_new_pkt;
    logic              w_ser_fire;
    logic              w_ser_last;
    logic              w_ser_free;
    logic              w_des_fire;
    logic              w_up_fire;
    logic [FW-1:0]     w_flit;
    logic              w_unused_d2_msb;

    assign w_dn_fire  = bus.host_dn_valid & bus.host_dn_ready;
    assign w_is_ctl   = (bus.host_dn_data[31:30] == 2'b10);
    assign w_conf_wr  = w_dn_fire & (r_dn_state == S_WORD) & w_is_ctl & ~bus.host_dn_data[29];
    assign w_new_pkt  = w_dn_fire & (r_dn_state == S_ROUTE) & ~bus.host_dn_data[RTW-1];
    assign w_ser_fire = r_ser_busy & bus.top_ready_in;
    assign w_ser_last = w_ser_fire & (r_ser_idx == 2'd3);
    assign w_ser_free = ~r_ser_busy | w_ser_last;
    assign w_des_fire = bus.top_valid_in & bus.top_ready_out;
    assign w_up_fire  = bus.host_up_valid & bus.host_up_ready;

    // The core only stops taking words while a second packet waits behind a busy serializer.
    assign bus.host_dn_ready = r_rdy_en & ~r_buf_valid;
    assign bus.top_ready_out = r_rdy_en & ~r_des_full;
    assign bus.top_valid_out = r_ser_busy;
    assign bus.top_out       = w_flit;
    assign bus.host_up_valid = r_des_full;
    assign bus.host_up_data  = r_up_sel ? {{(32-FW){1'b0}}, r_des_h}
                                        : {r_des_d2, r_des_d1, r_des_d0};
    assign led               = {r_up_cnt, r_dn_cnt};
    assign w_unused_d2_msb   = bus.top_in[FW-1];

    for (genvar g = 0; g < NREG; g++) begin : g_conf
        assign conf_regs[g*16 +: 16] = r_conf[g];
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_flit = '0;
        case (r_ser_idx)
            2'd0: w_flit = {{(FW-RTW){1'b0}}, r_ser_route};
            2'd1: w_flit = r_ser_payload[10:0];
            2'd2: w_flit = r_ser_payload[21:11];
            2'd3: w_flit = {1'b0, r_ser_payload[31:22]};
            default: w_flit = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy_en   <= 1'b0;
            r_dn_state <= S_WORD;
            r_payload  <= '0;
            // NOTE: the config file is host-visible state, so every entry is reset, not just control.
            for (int i = 0; i < NREG; i++) r_conf[i] <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_dn_fire) begin
                case (r_dn_state)
                    S_WORD: begin
                        if (!w_is_ctl) begin
                            r_payload  <= bus.host_dn_data;
                            r_dn_state <= S_ROUTE;
                        end
                    end
                    default: r_dn_state <= S_WORD;
                endcase
            end
            if (w_conf_wr) r_conf[bus.host_dn_data[24 +: RIDW]] <= bus.host_dn_data[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_valid   <= 1'b0;
            r_buf_route   <= '0;
            r_buf_payload <= '0;
            r_ser_busy    <= 1'b0;
            r_ser_idx     <= '0;
            r_ser_route   <= '0;
            r_ser_payload <= '0;
            r_dn_cnt      <= '0;
        end else begin
            if (w_ser_fire) begin
                r_ser_idx <= r_ser_idx + 2'd1;
                if (w_ser_last) begin
                    r_ser_busy <= 1'b0;
                    r_dn_cnt   <= r_dn_cnt + 2'd1;
                end
            end
            // A freed serializer reloads in the same cycle so H follows the route word directly.
            if (w_ser_free && r_buf_valid) begin
                r_ser_busy    <= 1'b1;
                r_ser_idx     <= '0;
                r_ser_route   <= r_buf_route;
                r_ser_payload <= r_buf_payload;
                r_buf_valid   <= 1'b0;
            end else if (w_ser_free && w_new_pkt) begin
                r_ser_busy    <= 1'b1;
                r_ser_idx     <= '0;
                r_ser_route   <= bus.host_dn_data[RTW-1:0];
                r_ser_payload <= r_payload;
            end else if (w_new_pkt) begin
                r_buf_valid   <= 1'b1;
                r_buf_route   <= bus.host_dn_data[RTW-1:0];
                r_buf_payload <= r_payload;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_des_idx  <= '0;
            r_des_full <= 1'b0;
            r_up_sel   <= 1'b0;
            r_des_h    <= '0;
            r_des_d0   <= '0;
            r_des_d1   <= '0;
            r_des_d2   <= '0;
            r_up_cnt   <= '0;
        end else begin
            if (w_des_fire) begin
                r_des_idx <= r_des_idx + 2'd1;
                case (r_des_idx)
                    2'd0: r_des_h  <= bus.top_in;
                    2'd1: r_des_d0 <= bus.top_in;
                    2'd2: r_des_d1 <= bus.top_in;
                    default: begin
                        r_des_d2   <= bus.top_in[9:0];
                        r_des_full <= 1'b1;
                        r_up_sel   <= 1'b0;
                    end
                endcase
            end
            if (w_up_fire) begin
                if (!r_up_sel) begin
                    r_up_sel <= 1'b1;
                end else begin
                    r_des_full <= 1'b0;
                    r_up_cnt   <= r_up_cnt + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bz_host_core.sv
// Directed-vector bench for bz_host_core; expected flits and host words are queued
// by the stimulus and consumed by independent monitors on the falling edge.
module tb_bz_host_core;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [511:0] conf_regs;
    logic [3:0]   led;

    bz_host_core_if bus();

    bz_host_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .conf_regs (conf_regs),
        .led       (led)
    );

    always #5 clk = ~clk;

    int           checks   = 0;
    int           failures = 0;
    logic [10:0]  exp_flits[$];
    logic [31:0]  exp_up[$];
    logic [511:0] exp_conf;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flit monitor: every accepted outbound flit must match the next queued expectation.
    always @(negedge clk) begin
        if (reset_n && bus.top_valid_out && bus.top_ready_in) begin
            if (exp_flits.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_flit: got %0h expected none", bus.top_out);
            end else begin
                check("flit", {501'b0, bus.top_out}, {501'b0, exp_flits.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && bus.host_up_valid && bus.host_up_ready) begin
            if (exp_up.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_up_word: got %0h expected none", bus.host_up_data);
            end else begin
                check("up_word", {480'b0, bus.host_up_data}, {480'b0, exp_up.pop_front()});
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        bus.host_dn_data  = w;
        bus.host_dn_valid = 1'b1;
        @(negedge clk);
        while (!bus.host_dn_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL dn_ready_timeout: word %0h not accepted in 200 cycles", w);
        end
        @(posedge clk);
        #1;
        bus.host_dn_valid = 1'b0;
    endtask

    task automatic send_flit(input logic [10:0] f);
        int n = 0;
        bus.top_in       = f;
        bus.top_valid_in = 1'b1;
        @(negedge clk);
        while (!bus.top_ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL top_ready_timeout: flit %0h not accepted in 200 cycles", f);
        end
        @(posedge clk);
        #1;
        bus.top_valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_flits.size() != 0 || exp_up.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d flits and %0d words never seen",
                     exp_flits.size(), exp_up.size());
            exp_flits.delete();
            exp_up.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.host_dn_data  = '0;
        bus.host_dn_valid = 1'b0;
        bus.host_up_ready = 1'b1;
        bus.top_ready_in  = 1'b1;
        bus.top_in        = '0;
        bus.top_valid_in  = 1'b0;
        exp_conf          = '0;

        #12;
        check("rst_dn_ready",  {511'b0, bus.host_dn_ready}, 512'd0);
        check("rst_top_ready", {511'b0, bus.top_ready_out}, 512'd0);
        check("rst_top_valid", {511'b0, bus.top_valid_out}, 512'd0);
        check("rst_up_valid",  {511'b0, bus.host_up_valid}, 512'd0);
        check("rst_conf",      conf_regs, 512'd0);
        check("rst_led",       {508'b0, led}, 512'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rdy_before_clk", {511'b0, bus.host_dn_ready}, 512'd0);
        @(posedge clk);
        #1;
        check("dn_ready_after_clk",  {511'b0, bus.host_dn_ready}, 512'd1);
        check("top_ready_after_clk", {511'b0, bus.top_ready_out}, 512'd1);

        // Config writes, including the top register.
        send_word(32'h8500_ABCD);
        exp_conf[5*16 +: 16] = 16'hABCD;
        check("conf_reg5", conf_regs, exp_conf);
        send_word(32'h9F00_1234);
        exp_conf[31*16 +: 16] = 16'h1234;
        check("conf_reg31", conf_regs, exp_conf);
        check("conf_no_flit", {511'b0, bus.top_valid_out}, 512'd0);

        // Packet serialization.
        exp_flits.push_back(11'h003);
        exp_flits.push_back(11'h07C);
        exp_flits.push_back(11'h61E);
        exp_flits.push_back(11'h131);
        send_word(32'h4C70_F07C);
        send_word(32'd3);
        check("h_latency_valid", {511'b0, bus.top_valid_out}, 512'd1);
        check("h_latency_flit",  {501'b0, bus.top_out}, {501'b0, 11'h003});
        wait_drain();
        check("dn_cnt_1", {510'b0, led[1:0]}, 512'd1);

        // NOP and discarded packet.
        send_word(32'hBF00_0001);
        send_word(32'h1111_1111);
        send_word(32'h0000_0200);
        repeat (5) @(posedge clk);
        #1;
        check("nop_conf", conf_regs, exp_conf);
        check("discard_no_flit", {511'b0, bus.top_valid_out}, 512'd0);
        check("discard_dn_cnt", {510'b0, led[1:0]}, 512'd1);

        // Inbound reassembly with host backpressure.
        bus.host_up_ready = 1'b0;
        exp_up.push_back(32'h07C0_3801);
        exp_up.push_back(32'h0000_0020);
        send_flit(11'h020);
        send_flit(11'h001);
        send_flit(11'h007);
        send_flit(11'h01F);
        repeat (3) begin
            @(negedge clk);
            check("up_hold_valid", {511'b0, bus.host_up_valid}, 512'd1);
            check("up_hold_data",  {480'b0, bus.host_up_data}, {480'b0, 32'h07C0_3801});
            check("up_full_ready", {511'b0, bus.top_ready_out}, 512'd0);
        end
        @(posedge clk);
        #1;
        bus.host_up_ready = 1'b1;
        wait_drain();
        check("up_cnt_1", {510'b0, led[3:2]}, 512'd1);
        check("up_ready_back", {511'b0, bus.top_ready_out}, 512'd1);

        // Link backpressure mid-packet, with a second packet queued behind it.
        exp_flits.push_back(11'h005);
        exp_flits.push_back(11'h678);
        exp_flits.push_back(11'h68A);
        exp_flits.push_back(11'h048);
        exp_flits.push_back(11'h1FF);
        exp_flits.push_back(11'h001);
        exp_flits.push_back(11'h000);
        exp_flits.push_back(11'h000);
        send_word(32'h1234_5678);
        send_word(32'd5);
        @(posedge clk);
        #1;
        bus.top_ready_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", {511'b0, bus.top_valid_out}, 512'd1);
            check("stall_flit",  {501'b0, bus.top_out}, {501'b0, 11'h678});
        end
        @(posedge clk);
        #1;
        send_word(32'h0000_0001);
        send_word(32'h0000_01FF);
        check("dn_ready_full", {511'b0, bus.host_dn_ready}, 512'd0);
        check("stall_flit_still", {501'b0, bus.top_out}, {501'b0, 11'h678});
        bus.top_ready_in = 1'b1;
        wait_drain();
        check("dn_cnt_3", {510'b0, led[1:0]}, 512'd3);
        check("dn_ready_free", {511'b0, bus.host_dn_ready}, 512'd1);

        // Asynchronous reset in the middle of a stalled packet.
        bus.top_ready_in = 1'b0;
        send_word(32'h8A00_5555);
        send_word(32'h0ABC_DEF0);
        send_word(32'd2);
        check("pre_rst_valid", {511'b0, bus.top_valid_out}, 512'd1);
        #3;
        reset_n = 1'b0;
        exp_conf = '0;
        #1;
        check("mid_rst_top_valid", {511'b0, bus.top_valid_out}, 512'd0);
        check("mid_rst_up_valid",  {511'b0, bus.host_up_valid}, 512'd0);
        check("mid_rst_conf",      conf_regs, exp_conf);
        check("mid_rst_dn_ready",  {511'b0, bus.host_dn_ready}, 512'd0);
        check("mid_rst_led",       {508'b0, led}, 512'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_dn_ready_low", {511'b0, bus.host_dn_ready}, 512'd0);
        @(posedge clk);
        #1;
        check("rel_dn_ready",  {511'b0, bus.host_dn_ready}, 512'd1);
        check("rel_top_ready", {511'b0, bus.top_ready_out}, 512'd1);
        bus.top_ready_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_dropped_pkt", {511'b0, bus.top_valid_out}, 512'd0);
        check("rst_queues_empty", 512'(exp_flits.size() + exp_up.size()), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
